// File: rtl/dh_pkg.sv
// Shared definitions for the Diffie-Hellman modular exponentiation sequencer
// and the peer modular multiplier.
package dh_pkg;

    localparam int unsigned DH_DATA_W = 32;
    localparam int unsigned DH_EXP_W  = 32;

    localparam logic MM_OP_MUL = 1'b0;
    localparam logic MM_OP_SQR = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        BIT,
        MUL,
        SQR,
        DONE
    } state_t;

endpackage

// File: rtl/dh_modexp_seq.sv
// Right-to-left square-and-multiply sequencer computing base^exponent mod p
// through an external req/ack modular multiplier.
module dh_modexp_seq
    import dh_pkg::*;
#(
    parameter int unsigned DATA_W = DH_DATA_W,
    parameter int unsigned EXP_W  = DH_EXP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] base,
    input  logic [EXP_W-1:0]  exponent,
    input  logic [DATA_W-1:0] p,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] result,
    output logic              mm_req,
    output logic              mm_op,
    output logic [DATA_W-1:0] mm_a,
    output logic [DATA_W-1:0] mm_b,
    output logic [DATA_W-1:0] mm_p,
    input  logic              mm_ack,
    input  logic [DATA_W-1:0] mm_res
);

    state_t            r_state;
    state_t            w_next;

    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_b;
    logic [EXP_W-1:0]  r_e;
    logic [DATA_W-1:0] r_result;
    logic              r_err;
    logic              r_mm_req;
    logic              r_mm_op;
    logic [DATA_W-1:0] r_mm_a;
    logic [DATA_W-1:0] r_mm_b;
    logic [DATA_W-1:0] r_mm_p;

    logic              w_ack;
    logic              w_bad;
    logic              w_last;

    // Acks outside an outstanding request are ignored.
    assign w_ack  = r_mm_req & mm_ack;
    assign w_bad  = (r_mm_p < DATA_W'(2)) || (r_b >= r_mm_p);
    assign w_last = (r_e[EXP_W-1:1] == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = CHECK;
            CHECK:   w_next = (w_bad || (r_e == '0)) ? DONE : BIT;
            BIT:     w_next = r_e[0] ? MUL : SQR;
            MUL:     if (w_ack) w_next = w_last ? DONE : SQR;
            SQR:     if (w_ack) w_next = BIT;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= DATA_W'(1);
            r_b      <= '0;
            r_e      <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_mm_req <= 1'b0;
            r_mm_op  <= MM_OP_MUL;
            r_mm_a   <= '0;
            r_mm_b   <= '0;
            r_mm_p   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mm_p <= p;
                        r_b    <= base;
                        r_e    <= exponent;
                        r_acc  <= DATA_W'(1);
                    end
                end
                CHECK: begin
                    if (w_bad) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                    end else if (r_e == '0) begin
                        r_result <= DATA_W'(1);
                        r_err    <= 1'b0;
                    end
                end
                BIT: begin
                    r_mm_req <= 1'b1;
                    if (r_e[0]) begin
                        r_mm_op <= MM_OP_MUL;
                        r_mm_a  <= r_acc;
                        r_mm_b  <= r_b;
                    end else begin
                        r_mm_op <= MM_OP_SQR;
                        r_mm_a  <= r_b;
                        r_mm_b  <= r_b;
                    end
                end
                MUL: begin
                    if (w_ack) begin
                        r_mm_req <= 1'b0;
                        r_acc    <= mm_res;
                        if (w_last) begin
                            r_result <= mm_res;
                            r_err    <= 1'b0;
                        end else begin
                            r_mm_op <= MM_OP_SQR;
                            r_mm_a  <= r_b;
                            r_mm_b  <= r_b;
                        end
                    end
                end
                SQR: begin
                    // Entered straight from MUL with req low; re-raise it one cycle later.
                    if (w_ack) begin
                        r_mm_req <= 1'b0;
                        r_b      <= mm_res;
                        r_e      <= r_e >> 1;
                    end else if (!r_mm_req) begin
                        r_mm_req <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = r_state inside {CHECK, BIT, MUL, SQR};
    assign done   = (r_state == DONE);
    assign err    = (r_state == DONE) & r_err;
    assign result = r_result;
    assign mm_req = r_mm_req;
    assign mm_op  = r_mm_op;
    assign mm_a   = r_mm_a;
    assign mm_b   = r_mm_b;
    assign mm_p   = r_mm_p;

endmodule

// File: doc/dh_modexp_seq.md
Name: dh_modexp_seq

Overview:
Sequencer for the Diffie-Hellman modular exponentiation g^x mod p. It uses right-to-left square-and-multiply and drives one external modular multiplier (a*b mod p) through a req/ack handshake. It replaces the wide single-shot exponent-then-reduce path, so that R1/R2 generation reuses one mod-multiply datapath. It sits between the key-exchange top level (start/done) and the shared mod-multiply unit.

Parameters:
DATA_W, 32, width of p, base, result and multiplier operands
EXP_W, 32, width of the private exponent

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  request a new exponentiation; accepted only in IDLE
base  in  DATA_W  generator g or peer public value; sampled on accepted start
exponent  in  EXP_W  private exponent; sampled on accepted start
p  in  DATA_W  modulus; sampled on accepted start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle completion pulse
err  out  1  valid with done; operands illegal
result  out  DATA_W  base^exponent mod p; held from done until the next accepted start
mm_req  out  1  multiplier request; held until ack
mm_op  out  1  0 = multiply (acc*b), 1 = square (b*b); stable while mm_req
mm_a  out  DATA_W  multiplier operand A; stable while mm_req
mm_b  out  DATA_W  multiplier operand B; stable while mm_req
mm_p  out  DATA_W  latched modulus
mm_ack  in  1  one-cycle pulse; mm_res valid in the same cycle
mm_res  in  DATA_W  (mm_a*mm_b) mod mm_p

Behaviour:
- Reset (asynchronous, rst=1): state IDLE; busy=0, done=0, err=0, mm_req=0, mm_op=0, result=0, mm_a=0, mm_b=0, mm_p=0; internal acc=1, b=0, e=0.
- Reset mid-operation aborts at once. mm_req falls asynchronously. The multiplier must tolerate an abandoned request.
- States: IDLE, CHECK, BIT, MUL, SQR, DONE.
- IDLE:
  - start=1 latches p, base and exponent into mm_p, b and e; sets acc=1; goes to CHECK.
  - start is ignored in every other state. There is no queueing.
- CHECK (1 cycle):
  - If p<2 or base>=p: done=1, err=1, result=0; go to DONE.
  - Else if e==0: done=1, err=0, result=1; go to DONE.
  - Else go to BIT.
- BIT (1 cycle):
  - If e[0]=1: go to MUL with mm_a=acc, mm_b=b, mm_op=0.
  - Else go to SQR with mm_a=b, mm_b=b, mm_op=1.
- MUL: mm_req=1 until mm_ack.
  - On ack: acc<=mm_res and mm_req<=0.
  - If (e>>1)==0: result<=mm_res, done<=1, go to DONE. The trailing square is skipped.
  - Else go to SQR.
- SQR: mm_req=1 until mm_ack.
  - On ack: b<=mm_res, e<=e>>1, mm_req<=0, go to BIT.
- mm_req rises the cycle after the BIT/MUL decision. mm_ack received while mm_req=0 is ignored.
- DONE (1 cycle):
  - done and err are high during this state only.
  - busy is 0 when done is high.
  - Returns to IDLE. A start in the following IDLE cycle is accepted.
- Operation count for exponent e: popcount(e) multiplies plus floor(log2 e) squares.
- No arithmetic is done locally: no comparison beyond CHECK, no products.

Decomposition:
- Package dh_pkg holds:
  - the state enum (IDLE, CHECK, BIT, MUL, SQR, DONE);
  - constants MM_OP_MUL=0 and MM_OP_SQR=1;
  - the default DATA_W/EXP_W localparams shared with the multiplier.
- No sub-module. The FSM plus operand registers is one block. The modular multiplier is a separate existing/peer unit instantiated at top level.

Test Plan:
- Bench multiplier model: ack 3 cycles after req.
- base=5, exponent=6, p=23 -> result=8, err=0. Multiplier sequence is SQR, MUL, SQR, MUL (4 handshakes).
- base=5, exponent=15, p=23 -> result=19. Then base=19, exponent=6 -> result=2. Then base=8, exponent=15 -> result=2 (shared secret match).
- exponent=0, base=7, p=23 -> done two cycles after start, result=1, no mm_req. p=1 or base=23 with p=23 -> done with err=1, result=0, no mm_req.
- Assert rst during the second MUL of the 5^15 case -> mm_req, busy and done go low immediately. Next start 5^6 mod 23 returns 8.
- Pulse start while busy and random mm_ack while mm_req=0 -> both ignored, result unchanged. Vary ack latency 1..10 cycles -> identical results.
- exponent=0xFFFFFFFF, base=2, p=4294967291 -> result matches the reference model. Exactly 32 MUL and 31 SQR handshakes.
